// File: rtl/sync_hold_priority_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
// The arbiter samples req_i on each rising edge and presents registered grant outputs one cycle later.
interface sync_hold_priority_arbiter_if #(
  parameter int num_ports = 5
) ();
  localparam int ID_W = $clog2(num_ports);

  logic [num_ports-1:0] req_i;
  logic [num_ports-1:0] gnt_o;
  logic                 gnt_valid_o;
  logic [ID_W-1:0]      gnt_id_o;
  logic                 preempt_o;

  modport master (output req_i, input gnt_o, gnt_valid_o, gnt_id_o, preempt_o);
  modport slave  (input req_i, output gnt_o, gnt_valid_o, gnt_id_o, preempt_o);
endinterface

// File: rtl/sync_hold_priority_arbiter.sv
// Registered fixed-priority arbiter (port 0 highest) with a bounded hold time per owner.
// An owner keeps its grant while requesting; after max_hold cycles it yields if anyone else requests.
module sync_hold_priority_arbiter #(
  parameter int num_ports = 5,
  parameter int max_hold  = 8
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  sync_hold_priority_arbiter_if.slave            bus,
  output logic                                   dbg_state_o,
  output logic [$clog2(max_hold+1)-1:0]          dbg_hold_cnt_o
);
  localparam int ID_W  = $clog2(num_ports);
  localparam int CNT_W = $clog2(max_hold + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(max_hold);
  localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t               state;
  logic [ID_W-1:0]      owner;
  logic [CNT_W-1:0]     hold_cnt;

  logic [num_ports-1:0] others;
  logic                 req_any;
  logic                 oth_any;
  logic                 owner_req;
  logic [ID_W-1:0]      req_idx;
  logic [ID_W-1:0]      oth_idx;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [num_ports-1:0] v);
    lowest_idx = '0;
    for (int i = num_ports - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = ID_W'(i);
    end
  endfunction

  function automatic logic [num_ports-1:0] onehot(input logic [ID_W-1:0] idx);
    onehot = '0;
    onehot[idx] = 1'b1;
  endfunction

  // "others" masks the current owner out for a single arbitration only.
  always_comb begin
    others        = bus.req_i;
    others[owner] = 1'b0;
    req_any       = |bus.req_i;
    oth_any       = |others;
    owner_req     = bus.req_i[owner];
    req_idx       = lowest_idx(bus.req_i);
    oth_idx       = lowest_idx(others);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state           <= IDLE;
      owner           <= '0;
      hold_cnt        <= '0;
      bus.gnt_o       <= '0;
      bus.gnt_valid_o <= 1'b0;
      bus.gnt_id_o    <= '0;
      bus.preempt_o   <= 1'b0;
    end else begin
      bus.preempt_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            state           <= GRANT;
            owner           <= req_idx;
            hold_cnt        <= ONE_CNT;
            bus.gnt_o       <= onehot(req_idx);
            bus.gnt_valid_o <= 1'b1;
            bus.gnt_id_o    <= req_idx;
          end
        end
        GRANT: begin
          if (!owner_req) begin
            if (oth_any) begin
              owner        <= oth_idx;
              hold_cnt     <= ONE_CNT;
              bus.gnt_o    <= onehot(oth_idx);
              bus.gnt_id_o <= oth_idx;
            end else begin
              state           <= IDLE;
              owner           <= '0;
              hold_cnt        <= '0;
              bus.gnt_o       <= '0;
              bus.gnt_valid_o <= 1'b0;
              bus.gnt_id_o    <= '0;
            end
          end else if (hold_cnt == MAX_CNT && oth_any) begin
            owner         <= oth_idx;
            hold_cnt      <= ONE_CNT;
            bus.gnt_o     <= onehot(oth_idx);
            bus.gnt_id_o  <= oth_idx;
            bus.preempt_o <= 1'b1;
          end else if (hold_cnt == MAX_CNT) begin
            hold_cnt <= ONE_CNT;
          end else begin
            hold_cnt <= hold_cnt + ONE_CNT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dbg_state_o    = state;
  assign dbg_hold_cnt_o = hold_cnt;
endmodule

// File: tb/tb_sync_hold_priority_arbiter.sv
// Directed bench: a 5-port/hold-8 arbiter and a 4-port/hold-1 arbiter sharing clock and reset.
// Expected grants are hand-derived per step; per-cycle invariants are checked on the falling edge.
module tb_sync_hold_priority_arbiter;
  logic clk_i;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  sync_hold_priority_arbiter_if #(.num_ports(5)) bus0 ();
  sync_hold_priority_arbiter_if #(.num_ports(4)) bus1 ();
  logic       dbg_state0, dbg_state1;
  logic [3:0] dbg_hold0;
  logic [0:0] dbg_hold1;

  sync_hold_priority_arbiter #(.num_ports(5), .max_hold(8)) u_dut0 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus0.slave),
    .dbg_state_o(dbg_state0), .dbg_hold_cnt_o(dbg_hold0)
  );

  sync_hold_priority_arbiter #(.num_ports(4), .max_hold(1)) u_dut1 (
    .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus1.slave),
    .dbg_state_o(dbg_state1), .dbg_hold_cnt_o(dbg_hold1)
  );

  // clock/reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic check_vec(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // port < 0 means idle
  task automatic chk0(input string tag, input int port, input logic pre);
    logic [4:0] g;
    logic [2:0] id;
    g  = (port < 0) ? 5'b0 : (5'b1 << port);
    id = (port < 0) ? 3'd0 : 3'(port);
    check_vec(tag, {6'b0, bus0.gnt_o, bus0.gnt_valid_o, bus0.gnt_id_o, bus0.preempt_o},
              {6'b0, g, (port >= 0), id, pre});
  endtask

  task automatic chk1(input string tag, input int port, input logic pre);
    logic [3:0] g;
    logic [1:0] id;
    g  = (port < 0) ? 4'b0 : (4'b1 << port);
    id = (port < 0) ? 2'd0 : 2'(port);
    check_vec(tag, {8'b0, bus1.gnt_o, bus1.gnt_valid_o, bus1.gnt_id_o, bus1.preempt_o},
              {8'b0, g, (port >= 0), id, pre});
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // requests seen at the last rising edge, for the "grant only to a requester" invariant
  logic [4:0] req0_q;
  logic [3:0] req1_q;
  always @(posedge clk_i) begin
    req0_q = bus0.req_i;
    req1_q = bus1.req_i;
  end

  always @(negedge clk_i) begin
    if (rst_ni) begin
      checks++;
      assert ($onehot0(bus0.gnt_o)
              && bus0.gnt_o === (bus0.gnt_valid_o ? (5'b1 << bus0.gnt_id_o) : 5'b0)
              && (!bus0.preempt_o || bus0.gnt_valid_o)
              && (!bus0.gnt_valid_o || req0_q[bus0.gnt_id_o])) else begin
        errors++;
        $error("FAIL inv0: observed gnt=%b v=%b id=%0d pre=%b req=%b expected consistent grant",
               bus0.gnt_o, bus0.gnt_valid_o, bus0.gnt_id_o, bus0.preempt_o, req0_q);
      end
      checks++;
      assert ($onehot0(bus1.gnt_o)
              && bus1.gnt_o === (bus1.gnt_valid_o ? (4'b1 << bus1.gnt_id_o) : 4'b0)
              && (!bus1.preempt_o || bus1.gnt_valid_o)
              && (!bus1.gnt_valid_o || req1_q[bus1.gnt_id_o])) else begin
        errors++;
        $error("FAIL inv1: observed gnt=%b v=%b id=%0d pre=%b req=%b expected consistent grant",
               bus1.gnt_o, bus1.gnt_valid_o, bus1.gnt_id_o, bus1.preempt_o, req1_q);
      end
    end
  end

  initial begin
    int cur;
    rst_ni     = 1'b0;
    bus0.req_i = 5'b11111;
    bus1.req_i = 4'b0000;
    repeat (3) tick();
    chk0("reset_hold0", -1, 1'b0);
    chk1("reset_hold1", -1, 1'b0);
    check_vec("reset_dbg", {11'b0, dbg_state0, dbg_hold0}, 16'h0);

    rst_ni = 1'b1;
    tick();
    chk0("first_grant", 0, 1'b0);
    check_vec("first_hold", {12'b0, dbg_hold0}, 16'd1);

    // priority and back-to-back handover
    bus0.req_i = 5'b00000; tick(); chk0("to_idle", -1, 1'b0);
    bus0.req_i = 5'b10110; tick(); chk0("priority", 1, 1'b0);
    bus0.req_i = 5'b10100; tick(); chk0("back_to_back", 2, 1'b0);
    bus0.req_i = 5'b00000; tick(); chk0("idle_again", -1, 1'b0);

    // higher priority arrives mid-grant: no early pre-emption
    bus0.req_i = 5'b01000; tick(); chk0("port3_grant", 3, 1'b0);
    bus0.req_i = 5'b01001;
    for (int i = 0; i < 7; i++) begin
      tick(); chk0("no_early", 3, 1'b0);
    end
    tick(); chk0("expiry_preempt", 0, 1'b1);
    tick(); chk0("preempt_pulse_end", 0, 1'b0);
    bus0.req_i = 5'b00000; tick(); chk0("idle_3", -1, 1'b0);

    // expiry without contention
    bus0.req_i = 5'b00100;
    for (int i = 0; i < 20; i++) begin
      tick(); chk0("no_contention", 2, 1'b0);
    end
    bus0.req_i = 5'b00000; tick(); chk0("idle_4", -1, 1'b0);

    // starvation bound: port0/port1 alternate every 8 cycles
    bus0.req_i = 5'b00011;
    cur = 0;
    tick(); chk0("starve_start", cur, 1'b0);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 7; i++) begin
        tick(); chk0("starve_hold", cur, 1'b0);
      end
      tick(); cur = 1 - cur; chk0("starve_switch", cur, 1'b1);
    end
    bus0.req_i = 5'b00000; tick(); chk0("idle_5", -1, 1'b0);

    // max_hold = 1: contenders rotate each cycle, excluding previous owner
    bus1.req_i = 4'b1111;
    tick(); chk1("mh1_first", 0, 1'b0);
    tick(); chk1("mh1_rot1", 1, 1'b1);
    tick(); chk1("mh1_rot2", 0, 1'b1);
    tick(); chk1("mh1_rot3", 1, 1'b1);
    bus1.req_i = 4'b0100;
    tick(); chk1("mh1_release", 2, 1'b0);
    tick(); chk1("mh1_alone", 2, 1'b0);
    bus1.req_i = 4'b0000;
    tick(); chk1("mh1_idle", -1, 1'b0);

    // asynchronous reset mid-grant
    bus0.req_i = 5'b00100;
    tick(); chk0("mid_grant", 2, 1'b0);
    repeat (4) tick();
    check_vec("mid_hold5", {12'b0, dbg_hold0}, 16'd5);
    #1 rst_ni = 1'b0;
    #1;
    chk0("async_reset", -1, 1'b0);
    check_vec("async_reset_dbg", {11'b0, dbg_state0, dbg_hold0}, 16'h0);
    tick();
    rst_ni = 1'b1;
    tick();
    chk0("after_reset", 2, 1'b0);
    check_vec("after_reset_hold", {12'b0, dbg_hold0}, 16'd1);

    bus0.req_i = 5'b00000;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
